// File: rtl/pb_enc_pkg.sv
// Shared types and constants for the protobuf scalar encode path.
package pb_enc_pkg;

  typedef enum logic [1:0] {
    ENC_UINT64 = 2'd0,
    ENC_SINT32 = 2'd1,
    ENC_SINT64 = 2'd2,
    ENC_INT32  = 2'd3
  } enc_type_e;

  localparam int unsigned VARINT_MAX_BYTES = 10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/varint_len.sv
// LEB128 byte count of a 64-bit value: the highest non-zero 7-bit group sets the length.
module varint_len
  import pb_enc_pkg::*;
#(
  parameter int unsigned N_GROUPS = VARINT_MAX_BYTES
) (
  input  logic [63:0] i_value,
  output logic [3:0]  o_len
);

  logic [N_GROUPS-1:1] w_grp_nz;

  always_comb begin
    w_grp_nz = '0;
    for (int unsigned i = 1; i < N_GROUPS; i++) begin
      w_grp_nz[i] = |((i_value >> (7 * i)) & 64'h7F);
    end
  end

  // Ascending scan so the highest non-zero group wins; zero still needs one byte.
  always_comb begin
    o_len = 4'd1;
    for (int unsigned i = 1; i < N_GROUPS; i++) begin
      if (w_grp_nz[i]) o_len = 4'(i + 1);
    end
  end

endmodule

// File: rtl/varint_field_serializer.sv
// Zigzag/sign-extend transform of one scalar field, then LEB128 emission one byte per cycle.
module varint_field_serializer
  import pb_enc_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned MAX_BYTES = VARINT_MAX_BYTES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic [1:0]       in_type,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_last,
  output logic [3:0]       out_len,
  output logic             busy,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] byte_cnt
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [63:0]        r_sr;
  logic [3:0]         r_rem;
  logic [3:0]         r_out_len;
  logic [CNT_W-1:0]   r_byte_cnt;
  logic [63:0]        w_xform;
  logic [3:0]         w_len;
  logic               w_accept;
  logic               w_fire;
  logic               w_last_byte;

  always_comb begin
    w_xform = in_data;
    unique case (enc_type_e'(in_type))
      ENC_UINT64: w_xform = in_data;
      ENC_SINT32: w_xform = {32'd0, (in_data[31:0] << 1) ^ {32{in_data[31]}}};
      ENC_SINT64: w_xform = (in_data << 1) ^ {64{in_data[63]}};
      ENC_INT32:  w_xform = {{32{in_data[31]}}, in_data[31:0]};
    endcase
  end

  varint_len #(
    .N_GROUPS (MAX_BYTES)
  ) u_len (
    .i_value (w_xform),
    .o_len   (w_len)
  );

  assign w_last_byte = (r_rem == 4'd1);
  assign w_accept    = in_valid && in_ready;
  assign w_fire      = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = S_EMIT;
      S_EMIT: if (out_ready && w_last_byte && !in_valid) w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_byte  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    unique case (r_state)
      S_IDLE: in_ready = 1'b1;
      S_EMIT: begin
        in_ready  = w_last_byte && out_ready;
        out_valid = 1'b1;
        out_byte  = {(r_rem > 4'd1), r_sr[6:0]};
        out_last  = w_last_byte;
        busy      = 1'b1;
      end
    endcase
  end

  // A new field loaded on the final handshake takes priority over the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr      <= '0;
      r_rem     <= '0;
      r_out_len <= '0;
    end else if (w_accept) begin
      r_sr      <= w_xform;
      r_rem     <= w_len;
      r_out_len <= w_len;
    end else if (w_fire) begin
      r_sr  <= r_sr >> 7;
      r_rem <= r_rem - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_byte_cnt <= '0;
    else if (cnt_clr)              r_byte_cnt <= '0;
    else if (w_fire && (r_byte_cnt != '1)) r_byte_cnt <= r_byte_cnt + CNT_W'(1);
  end

  assign out_len  = r_out_len;
  assign byte_cnt = r_byte_cnt;

endmodule

// File: tb/tb_varint_field_serializer.sv
// Directed vectors for varint_field_serializer with hand-computed byte sequences.
module tb_varint_field_serializer;

  localparam int unsigned CNT_W = 5;

  typedef logic [7:0] bytes_t [10];

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_data;
  logic [1:0]       in_type;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_byte;
  logic             out_last;
  logic [3:0]       out_len;
  logic             busy;
  logic             cnt_clr;
  logic [CNT_W-1:0] byte_cnt;

  int n_vec = 0;
  int n_err = 0;

  varint_field_serializer #(
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_type   (in_type),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .out_len   (out_len),
    .busy      (busy),
    .cnt_clr   (cnt_clr),
    .byte_cnt  (byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clr_cnt();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  task automatic run_field(input string tag, input logic [1:0] ty, input logic [63:0] d,
                           input int n, input bytes_t exp);
    @(negedge clk);
    in_valid  = 1'b1;
    in_type   = ty;
    in_data   = d;
    out_ready = 1'b1;
    #1 chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      #1;
      chk($sformatf("%s valid[%0d]", tag, k), 64'(out_valid), 64'd1);
      chk($sformatf("%s byte[%0d]", tag, k), 64'(out_byte), 64'(exp[k]));
      chk($sformatf("%s last[%0d]", tag, k), 64'(out_last), 64'(k == n - 1));
      chk($sformatf("%s len[%0d]", tag, k), 64'(out_len), 64'(n));
      @(negedge clk);
    end
    #1 chk({tag, " idle"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_type   = 2'd0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_byte", 64'(out_byte), 64'd0);
    chk("rst out_last", 64'(out_last), 64'd0);
    chk("rst out_len", 64'(out_len), 64'd0);
    chk("rst byte_cnt", 64'(byte_cnt), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_field("sint32 -1", 2'd1, 64'h00000000_FFFFFFFF, 1, '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    run_field("sint64 -2", 2'd2, 64'hFFFFFFFF_FFFFFFFE, 1, '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    run_field("uint64 0", 2'd0, 64'd0, 1, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    run_field("uint64 300", 2'd0, 64'd300, 2, '{8'hAC, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    run_field("uint64 127", 2'd0, 64'd127, 1, '{8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    run_field("uint64 128", 2'd0, 64'd128, 2, '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    run_field("sint32 hi ignored", 2'd1, 64'hDEADBEEF_00000001, 1, '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    run_field("int32 hi ignored", 2'd3, 64'hFFFFFFFF_0000007F, 1, '{8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    run_field("sint32 min", 2'd1, 64'h00000000_80000000, 5, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    run_field("uint64 max", 2'd0, 64'hFFFFFFFF_FFFFFFFF, 10, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01});

    clr_cnt();
    run_field("int32 min", 2'd3, 64'h00000000_80000000, 10, '{8'h80, 8'h80, 8'h80, 8'h80, 8'hF8, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01});
    chk("int32 min byte_cnt", 64'(byte_cnt), 64'd10);

    // Backpressure on the first byte with a second field already waiting.
    @(negedge clk);
    in_valid  = 1'b1;
    in_type   = 2'd0;
    in_data   = 64'd300;
    out_ready = 1'b0;
    @(negedge clk);
    in_data = 64'd5;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp valid[%0d]", k), 64'(out_valid), 64'd1);
      chk($sformatf("bp byte[%0d]", k), 64'(out_byte), 64'hAC);
      chk($sformatf("bp last[%0d]", k), 64'(out_last), 64'd0);
      chk($sformatf("bp len[%0d]", k), 64'(out_len), 64'd2);
      chk($sformatf("bp in_ready[%0d]", k), 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release byte", 64'(out_byte), 64'hAC);
    chk("bp release in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    #1;
    chk("bp final byte", 64'(out_byte), 64'h02);
    chk("bp final last", 64'(out_last), 64'd1);
    chk("bp final in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("b2b valid", 64'(out_valid), 64'd1);
    chk("b2b byte", 64'(out_byte), 64'h05);
    chk("b2b len", 64'(out_len), 64'd1);
    chk("b2b last", 64'(out_last), 64'd1);
    @(negedge clk);
    #1 chk("b2b idle", 64'(out_valid), 64'd0);

    // Reset asserted partway through a 10-byte varint.
    clr_cnt();
    @(negedge clk);
    in_valid = 1'b1;
    in_type  = 2'd3;
    in_data  = 64'h00000000_80000000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("mid byte_cnt", 64'(byte_cnt), 64'd4);
    chk("mid byte", 64'(out_byte), 64'hF8);
    rst_n = 1'b0;
    #1;
    chk("mid rst out_valid", 64'(out_valid), 64'd0);
    chk("mid rst byte_cnt", 64'(byte_cnt), 64'd0);
    chk("mid rst busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post rst in_ready", 64'(in_ready), 64'd1);
    chk("post rst out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    #1 chk("post rst no replay", 64'(out_valid), 64'd0);

    // Back-to-back 10-byte fields drive the 5-bit counter into saturation.
    clr_cnt();
    @(negedge clk);
    in_valid = 1'b1;
    in_type  = 2'd0;
    in_data  = 64'hFFFFFFFF_FFFFFFFF;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      #1 chk($sformatf("stream valid[%0d]", k), 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    chk("sat idle", 64'(out_valid), 64'd0);
    chk("sat byte_cnt", 64'(byte_cnt), 64'd31);

    // Clear coinciding with a handshake wins.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 64'd300;
    @(negedge clk);
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    #1 chk("clr byte", 64'(out_byte), 64'hAC);
    @(negedge clk);
    cnt_clr = 1'b0;
    #1;
    chk("clr byte_cnt", 64'(byte_cnt), 64'd0);
    chk("clr next byte", 64'(out_byte), 64'h02);
    @(negedge clk);
    #1;
    chk("clr after byte_cnt", 64'(byte_cnt), 64'd1);
    chk("clr after idle", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
